// File: rtl/drv_pkg.sv
// drv_pkg: types and constants shared by the driver address sequencer
// and the driver register block.
package drv_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      ABORT = 2'd2
   } seq_state_t;

   localparam int unsigned NUM_MON   = 16;
   localparam int unsigned MON_BIN_W = 4;
   localparam int unsigned MON_CNT_W = 16;

endpackage

// File: rtl/addr_mon_bank.sv
// addr_mon_bank: 16 saturating per-bin beat counters with synchronous clear.
// Only built when ADDR_SEQ_MON_EN is defined.
`ifdef ADDR_SEQ_MON_EN
module addr_mon_bank
   import drv_pkg::*;
#(
   parameter int unsigned CNT_W = MON_CNT_W
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             inc,
   input  logic [MON_BIN_W-1:0]             bin,
   input  logic                             clr,
   output logic [NUM_MON-1:0][CNT_W-1:0]    cnts
);

   logic [NUM_MON-1:0][CNT_W-1:0] cnt_q, cnt_d;

   // Clear beats an increment in the same cycle; counts stick at all-ones.
   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (inc && (cnt_q[bin] != '1)) begin
         cnt_d[bin] = cnt_q[bin] + CNT_W'(1);
      end
   end

   // Counter register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   assign cnts = cnt_q;

endmodule
`endif

// File: rtl/addr_seq_ctrl.sv
// addr_seq_ctrl: pops addresses from the address FIFO, optionally expands
// each into a burst of consecutive addresses, and issues them on a
// valid/ready interface. Optional monitor bank under ADDR_SEQ_MON_EN.
module addr_seq_ctrl
   import drv_pkg::*;
#(
   parameter int unsigned ADDR_W    = 32,
   parameter int unsigned CNT_W     = 16,
   parameter int unsigned ADDR_STEP = 1,
   parameter int unsigned MON_LSB   = 12
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             active_program,
   input  logic                             abort_program,
   input  logic                             freeze_addr_fifo,
   input  logic                             send_consec_addr,
   input  logic [7:0]                       consec_count,
   input  logic [ADDR_W-1:0]                fifo_dout,
   input  logic                             fifo_empty,
   output logic                             fifo_rd,
   output logic [ADDR_W-1:0]                drv_addr,
   output logic                             drv_valid,
   input  logic                             drv_ready,
   input  logic                             mon_clr,
   output logic [NUM_MON-1:0][CNT_W-1:0]    addr_mon_cnts,
   output logic                             seq_busy,
   output logic                             seq_done
);

   seq_state_t        state_q, state_d;
   logic [ADDR_W-1:0] cur_q, cur_d;
   logic [7:0]        rem_q, rem_d;
   logic              seq_done_q, seq_done_d;
   logic              pop_ok, pop, hs;

   assign pop_ok = active_program & ~fifo_empty & ~freeze_addr_fifo & ~abort_program;
   assign hs     = (state_q == ISSUE) & drv_ready;

   // Next-state, burst address/remaining count and pop strobe.
   always_comb begin
      state_d    = state_q;
      cur_d      = cur_q;
      rem_d      = rem_q;
      seq_done_d = 1'b0;
      pop        = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (pop_ok) begin
               pop     = 1'b1;
               cur_d   = fifo_dout;
               rem_d   = send_consec_addr ? consec_count : 8'd0;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            if (abort_program) begin
               rem_d   = 8'd0;
               state_d = ABORT;
            end else if (hs) begin
               if (rem_q != 8'd0) begin
                  cur_d = cur_q + ADDR_W'(ADDR_STEP);
                  rem_d = rem_q - 8'd1;
               end else if (pop_ok) begin
                  pop   = 1'b1;
                  cur_d = fifo_dout;
                  rem_d = send_consec_addr ? consec_count : 8'd0;
               end else begin
                  state_d    = IDLE;
                  seq_done_d = 1'b1;
               end
            end
         end
         ABORT: begin
            state_d    = IDLE;
            seq_done_d = 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   // Sequencer registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= IDLE;
         cur_q      <= '0;
         rem_q      <= '0;
         seq_done_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cur_q      <= cur_d;
         rem_q      <= rem_d;
         seq_done_q <= seq_done_d;
      end
   end

   assign fifo_rd   = pop & reset;
   assign drv_addr  = cur_q;
   assign drv_valid = (state_q == ISSUE);
   assign seq_busy  = (state_q != IDLE);
   assign seq_done  = seq_done_q;

`ifdef ADDR_SEQ_MON_EN
   addr_mon_bank #(
      .CNT_W (CNT_W)
   ) u_mon (
      .clk   (clk),
      .reset (reset),
      .inc   (hs),
      .bin   (cur_q[MON_LSB +: MON_BIN_W]),
      .clr   (mon_clr),
      .cnts  (addr_mon_cnts)
   );
`else
   logic unused_mon_clr;
   assign unused_mon_clr = mon_clr;
   assign addr_mon_cnts  = '0;
`endif

endmodule

// File: doc/addr_seq_ctrl.md
# addr_seq_ctrl

Sequences the driver's address path. It pops addresses from the address FIFO loaded by the driver register block and presents them to the driver datapath on a valid/ready interface. When consecutive mode is set, each popped address expands into a burst of consecutive addresses. It also maintains the 16 per-region address monitor counters that the register block reads back.

## Interface
- ADDR_W, 32, address width
- CNT_W, 16, monitor counter width
- ADDR_STEP, 1, increment between consecutive burst addresses
- MON_LSB, 12, low bit of the 4-bit monitor bin field in the issued address
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset; one clock domain
- active_program  in  1  program running, level from the register block
- abort_program  in  1  abort request, level
- freeze_addr_fifo  in  1  inhibit FIFO pops
- send_consec_addr  in  1  enable burst expansion
- consec_count  in  8  number of extra addresses per burst
- fifo_dout  in  ADDR_W  head of address FIFO (first-word fall-through)
- fifo_empty  in  1  FIFO empty
- fifo_rd  out  1  pop strobe; combinational from state and inputs
- drv_addr  out  ADDR_W  address to the datapath
- drv_valid  out  1  drv_addr valid
- drv_ready  in  1  datapath accepts the beat
- mon_clr  in  1  clear all monitor counters
- addr_mon_cnts  out  CNT_W x 16  per-bin beat counts
- seq_busy  out  1  burst in progress
- seq_done  out  1  one-cycle pulse when the sequence ends

## Operation
- **States:**
  - IDLE: drv_valid=0.
  - ISSUE: drv_valid=1.
  - ABORT: drv_valid=0; one cycle, then IDLE.
- **Pop condition:** pop_ok = active_program & !fifo_empty & !freeze_addr_fifo & !abort_program.
- **IDLE:**
  - If pop_ok: fifo_rd=1, then go to ISSUE.
  - On the pop, load cur=fifo_dout and rem = send_consec_addr ? consec_count : 0.
- **ISSUE, handshake (drv_valid & drv_ready):**
  - Counts one beat in bin drv_addr[MON_LSB+3:MON_LSB].
  - If rem≠0: cur += ADDR_STEP and rem−1.
  - If rem=0 and pop_ok: pop with fifo_rd=1 that cycle and reload cur/rem. The burst continues back-to-back with no bubble.
  - If rem=0 and !pop_ok: go to IDLE and pulse seq_done.
- **ISSUE, no handshake:** drv_addr and drv_valid are held stable.
- **Address arithmetic:** cur wraps modulo 2^ADDR_W. send_consec_addr and consec_count are sampled only at pop time.
- **freeze_addr_fifo:** blocks pops only; the current burst completes.
- **active_program falling mid-burst (end):** the burst completes, no further pops, then seq_done.
- **abort_program high in ISSUE:**
  - Next state is ABORT and rem is cleared.
  - The only case where drv_valid drops without a handshake.
  - A handshake in the same cycle still counts.
  - seq_done pulses on ABORT→IDLE.
- **abort_program in IDLE:** blocks pops.
- **Monitor counters:** saturate at 2^CNT_W−1.
  - mon_clr clears all counters.
  - mon_clr wins over a same-cycle increment; the result is 0.
- **seq_busy:** 1 in ISSUE and ABORT.

## Timing
- **Reset values:** state=IDLE; drv_valid, drv_addr, cur, rem, seq_busy, seq_done, counts = 0. fifo_rd=0 while reset is low.
- **Reset mid-burst:** reset takes effect the next edge. The burst is discarded; no seq_done.
- **Pop latency:** fifo_rd asserted in cycle N (IDLE) → drv_valid=1 with the popped address in N+1.
- **Throughput:** one beat per cycle while drv_ready=1, including across FIFO entries.
- **Counter latency:** the count updates on the edge after the handshake, so it is visible at N+1.
- **seq_done:** registered; high for exactly one cycle on entry to IDLE from ISSUE or ABORT.

## Configuration
- **ADDR_SEQ_MON_EN defined:** the monitor bank, bin decode and mon_clr logic are instantiated.
- **ADDR_SEQ_MON_EN undefined:**
  - addr_mon_cnts is tied to all zeros.
  - mon_clr is ignored.
  - Sequencing behaviour is identical.

## Structure
- **Package drv_pkg:**
  - state enum seq_state_t {IDLE, ISSUE, ABORT}
  - NUM_MON=16, MON_BIN_W=4, CNT_W default
  - Shared with the register block.
- **Sub-module addr_mon_bank:**
  - 16 saturating counters.
  - Inputs: inc, bin, clr.
  - Wrapped in ADDR_SEQ_MON_EN.

## Test plan
- **Single address:** FIFO={0x0000_2000}, consec off, drv_ready=1, active=1 → one beat at 0x2000; bin 2 count=1; seq_done one cycle after the beat.
- **Burst:** send_consec_addr=1, consec_count=3, FIFO={0x100, 0x500} → beats 0x100, 0x101, 0x102, 0x103, 0x500..0x503. No gap at the entry boundary; fifo_rd pulses exactly twice.
- **Backpressure:** drv_ready toggles 1,0,0,1 during a burst → drv_addr is held while ready=0; beat count = 4 for consec_count=3.
- **Freeze:** freeze_addr_fifo=1 with FIFO holding 2 entries → no fifo_rd and drv_valid stays 0. Release → pops resume on the next cycle.
- **Abort:** abort_program asserted on the 2nd beat of a consec_count=7 burst → drv_valid=0 next cycle; seq_done after one ABORT cycle; counts = beats actually handshaken; FIFO unchanged.
- **Saturation and clear:** force 0x10000 beats into bin 5 → count=0xFFFF. mon_clr together with a handshake → count=0. With ADDR_SEQ_MON_EN undefined → all counts 0.
